// File: rtl/victim_swap_ctrl_pkg.sv
// Shared cache definitions for the victim-swap controller: line and address
// widths, the controller state enum, the latched miss context and the
// victim hit qualification helper.
package victim_swap_ctrl_pkg;

    localparam int DCACHE_LINE_WIDTH = 64;
    localparam int VICTIM_ADDR_BITS  = 12;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOOKUP  = 3'd1,
        CHECK   = 3'd2,
        MEM_REQ = 3'd3,
        EVICT   = 3'd4,
        RESP    = 3'd5
    } victim_swap_state_e;

    // Everything captured from the dcache when a miss is accepted.
    typedef struct packed {
        logic [VICTIM_ADDR_BITS-1:0]  miss_addr;
        logic                         evict_valid;
        logic [VICTIM_ADDR_BITS-1:0]  evict_addr;
        logic [DCACHE_LINE_WIDTH-1:0] evict_data;
    } victim_swap_ctx_t;

    // A registered victim hit only counts when it answers the address we asked for.
    function automatic logic victim_match(
        input logic                        hit,
        input logic [VICTIM_ADDR_BITS-1:0] hit_addr,
        input logic [VICTIM_ADDR_BITS-1:0] miss_addr
    );
        return hit && (hit_addr == miss_addr);
    endfunction

endpackage

// File: rtl/victim_swap_ctrl_perf_cnt.sv
// Saturating hit/miss counters for the victim-swap controller. Only built
// into the controller when VICTIM_SWAP_PERF_CNT_EN is defined. Counters
// clear on rst only; flushes leave them untouched.
module victim_swap_perf_cnt
    import victim_swap_ctrl_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 hit_inc_i,
    input  logic                 miss_inc_i,
    output logic [CNT_WIDTH-1:0] hit_cnt_o,
    output logic [CNT_WIDTH-1:0] miss_cnt_o
);

    logic [CNT_WIDTH-1:0] hit_cnt_q,  hit_cnt_d;
    logic [CNT_WIDTH-1:0] miss_cnt_q, miss_cnt_d;

    // Increment on request, sticking at all-ones.
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (hit_inc_i && (hit_cnt_q != '1)) begin
            hit_cnt_d = hit_cnt_q + CNT_WIDTH'(1);
        end
        if (miss_inc_i && (miss_cnt_q != '1)) begin
            miss_cnt_d = miss_cnt_q + CNT_WIDTH'(1);
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;

endmodule

// File: rtl/victim_swap_ctrl.sv
// Victim-swap controller: on a dcache miss, probe the victim cache, fall
// back to memory on a victim miss, write the evicted dcache line into the
// victim cache and return the refill line to the dcache.
// Optional feature macro: VICTIM_SWAP_PERF_CNT_EN adds saturating hit/miss
// counters (victim_hit_cnt_o / victim_miss_cnt_o).
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a miss request
// LOOKUP  | victim cache performing its registered read of the miss address
// CHECK   | qualify victim hit; hit -> EVICT, miss -> MEM_REQ
// MEM_REQ | memory line read outstanding (held until ack, even if aborted)
// EVICT   | write the displaced dcache line into the victim cache
// RESP    | one-cycle refill strobe back to the dcache
module victim_swap_ctrl
    import victim_swap_ctrl_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush_i,
    input  logic                         miss_req_i,
    input  logic [VICTIM_ADDR_BITS-1:0]  miss_addr_i,
    input  logic                         evict_valid_i,
    input  logic [VICTIM_ADDR_BITS-1:0]  evict_addr_i,
    input  logic [DCACHE_LINE_WIDTH-1:0] evict_data_i,
    output logic                         busy_o,
    output logic                         refill_valid_o,
    output logic [DCACHE_LINE_WIDTH-1:0] refill_data_o,
    output logic                         refill_from_victim_o,
    output logic [VICTIM_ADDR_BITS-1:0]  victim_addr_r_o,
    input  logic                         victim_hit_i,
    input  logic [VICTIM_ADDR_BITS-1:0]  victim_addr_i,
    input  logic [DCACHE_LINE_WIDTH-1:0] victim_data_i,
    output logic                         victim_wr_en_o,
    output logic [VICTIM_ADDR_BITS-1:0]  victim_addr_w_o,
    output logic [DCACHE_LINE_WIDTH-1:0] victim_data_o,
    output logic                         mem_req_o,
    output logic [VICTIM_ADDR_BITS-1:0]  mem_addr_o,
    input  logic                         mem_ack_i,
    input  logic [DCACHE_LINE_WIDTH-1:0] mem_data_i
`ifdef VICTIM_SWAP_PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]         victim_hit_cnt_o,
    output logic [CNT_WIDTH-1:0]         victim_miss_cnt_o
`endif
);

    victim_swap_state_e           state_q, state_d;
    victim_swap_ctx_t             ctx_q, ctx_d;
    logic                         abort_q, abort_d;
    logic [DCACHE_LINE_WIDTH-1:0] refill_buf_q, refill_buf_d;
    logic                         from_victim_q, from_victim_d;

    // Next-state and datapath capture.
    always_comb begin
        state_d       = state_q;
        ctx_d         = ctx_q;
        abort_d       = abort_q;
        refill_buf_d  = refill_buf_q;
        from_victim_d = from_victim_q;

        case (state_q)
            IDLE: begin
                abort_d = 1'b0;
                // flush wins over a simultaneous request
                if (miss_req_i && !flush_i) begin
                    ctx_d.miss_addr   = miss_addr_i;
                    ctx_d.evict_valid = evict_valid_i;
                    ctx_d.evict_addr  = evict_addr_i;
                    ctx_d.evict_data  = evict_data_i;
                    state_d           = LOOKUP;
                end
            end
            LOOKUP: begin
                state_d = flush_i ? IDLE : CHECK;
            end
            CHECK: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else if (victim_match(victim_hit_i, victim_addr_i, ctx_q.miss_addr)) begin
                    refill_buf_d  = victim_data_i;
                    from_victim_d = 1'b1;
                    state_d       = EVICT;
                end else begin
                    state_d = MEM_REQ;
                end
            end
            MEM_REQ: begin
                // The memory read cannot be cancelled, so a flush only marks
                // the transaction as dead and we drain the ack.
                if (flush_i) begin
                    abort_d = 1'b1;
                end
                if (mem_ack_i) begin
                    if (abort_q || flush_i) begin
                        abort_d = 1'b0;
                        state_d = IDLE;
                    end else begin
                        refill_buf_d  = mem_data_i;
                        from_victim_d = 1'b0;
                        state_d       = EVICT;
                    end
                end
            end
            EVICT: begin
                state_d = flush_i ? IDLE : RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            ctx_q         <= '0;
            abort_q       <= 1'b0;
            refill_buf_q  <= '0;
            from_victim_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ctx_q         <= ctx_d;
            abort_q       <= abort_d;
            refill_buf_q  <= refill_buf_d;
            from_victim_q <= from_victim_d;
        end
    end

    // Output decode; a flush in EVICT/RESP suppresses that cycle's strobe.
    always_comb begin
        busy_o               = (state_q != IDLE);
        victim_addr_r_o      = '0;
        mem_req_o            = 1'b0;
        mem_addr_o           = '0;
        victim_wr_en_o       = 1'b0;
        victim_addr_w_o      = '0;
        victim_data_o        = '0;
        refill_valid_o       = 1'b0;
        refill_data_o        = refill_buf_q;
        refill_from_victim_o = 1'b0;

        if ((state_q == LOOKUP) || (state_q == CHECK)) begin
            victim_addr_r_o = ctx_q.miss_addr;
        end
        if (state_q == MEM_REQ) begin
            mem_req_o  = 1'b1;
            mem_addr_o = ctx_q.miss_addr;
        end
        if ((state_q == EVICT) && ctx_q.evict_valid && !flush_i) begin
            victim_wr_en_o  = 1'b1;
            victim_addr_w_o = ctx_q.evict_addr;
            victim_data_o   = ctx_q.evict_data;
        end
        if ((state_q == RESP) && !flush_i) begin
            refill_valid_o       = 1'b1;
            refill_from_victim_o = from_victim_q;
        end
    end

`ifdef VICTIM_SWAP_PERF_CNT_EN
    logic hit_inc;
    logic miss_inc;

    assign hit_inc  = (state_q == CHECK) && (state_d == EVICT);
    assign miss_inc = (state_q == CHECK) && (state_d == MEM_REQ);

    victim_swap_perf_cnt #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_perf_cnt (
        .clk        (clk),
        .rst        (rst),
        .hit_inc_i  (hit_inc),
        .miss_inc_i (miss_inc),
        .hit_cnt_o  (victim_hit_cnt_o),
        .miss_cnt_o (victim_miss_cnt_o)
    );
`else
    // CNT_WIDTH only sizes the counters; keep it referenced in the counter-less build.
    logic unused_cnt_width;
    assign unused_cnt_width = ^CNT_WIDTH;
`endif

endmodule

// File: tb/tb_victim_swap_ctrl.sv
module tb_victim_swap_ctrl;
    import victim_swap_ctrl_pkg::*;

    localparam int AW = VICTIM_ADDR_BITS;
    localparam int DW = DCACHE_LINE_WIDTH;
    localparam int CW = 4;
    localparam logic [DW-1:0] DEAD = 64'hDEAD_BEEF_DEAD_BEEF;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush_i = 1'b0;
    logic          miss_req_i = 1'b0;
    logic [AW-1:0] miss_addr_i = '0;
    logic          evict_valid_i = 1'b0;
    logic [AW-1:0] evict_addr_i = '0;
    logic [DW-1:0] evict_data_i = '0;
    logic          busy_o;
    logic          refill_valid_o;
    logic [DW-1:0] refill_data_o;
    logic          refill_from_victim_o;
    logic [AW-1:0] victim_addr_r_o;
    logic          victim_hit_i = 1'b0;
    logic [AW-1:0] victim_addr_i = '0;
    logic [DW-1:0] victim_data_i = '0;
    logic          victim_wr_en_o;
    logic [AW-1:0] victim_addr_w_o;
    logic [DW-1:0] victim_data_o;
    logic          mem_req_o;
    logic [AW-1:0] mem_addr_o;
    logic          mem_ack_i = 1'b0;
    logic [DW-1:0] mem_data_i = '0;
`ifdef VICTIM_SWAP_PERF_CNT_EN
    logic [CW-1:0] hit_cnt;
    logic [CW-1:0] miss_cnt;
`endif

    int checks = 0;
    int errors = 0;
    string cur_txn = "reset";

    // reference model state
    logic [DW-1:0] m_fill = '0;
    int m_hits = 0;
    int m_misses = 0;

    always #5 clk = ~clk;

    victim_swap_ctrl #(.CNT_WIDTH(CW)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .flush_i              (flush_i),
        .miss_req_i           (miss_req_i),
        .miss_addr_i          (miss_addr_i),
        .evict_valid_i        (evict_valid_i),
        .evict_addr_i         (evict_addr_i),
        .evict_data_i         (evict_data_i),
        .busy_o               (busy_o),
        .refill_valid_o       (refill_valid_o),
        .refill_data_o        (refill_data_o),
        .refill_from_victim_o (refill_from_victim_o),
        .victim_addr_r_o      (victim_addr_r_o),
        .victim_hit_i         (victim_hit_i),
        .victim_addr_i        (victim_addr_i),
        .victim_data_i        (victim_data_i),
        .victim_wr_en_o       (victim_wr_en_o),
        .victim_addr_w_o      (victim_addr_w_o),
        .victim_data_o        (victim_data_o),
        .mem_req_o            (mem_req_o),
        .mem_addr_o           (mem_addr_o),
        .mem_ack_i            (mem_ack_i),
        .mem_data_i           (mem_data_i)
`ifdef VICTIM_SWAP_PERF_CNT_EN
        ,
        .victim_hit_cnt_o     (hit_cnt),
        .victim_miss_cnt_o    (miss_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s [%s] got=%0h exp=%0h", tag, cur_txn, obs, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v > (2**CW - 1)) ? (2**CW - 1) : v;
    endfunction

    task automatic chk_idle();
        chk("idle_busy", busy_o, 0);
        chk("idle_rvalid", refill_valid_o, 0);
        chk("idle_rdata", refill_data_o, m_fill);
        chk("idle_src", refill_from_victim_o, 0);
        chk("idle_raddr", victim_addr_r_o, 0);
        chk("idle_wr", victim_wr_en_o, 0);
        chk("idle_waddr", victim_addr_w_o, 0);
        chk("idle_wdata", victim_data_o, 0);
        chk("idle_mreq", mem_req_o, 0);
        chk("idle_maddr", mem_addr_o, 0);
`ifdef VICTIM_SWAP_PERF_CNT_EN
        chk("hit_cnt", hit_cnt, sat(m_hits));
        chk("miss_cnt", miss_cnt, sat(m_misses));
`endif
    endtask

    // One miss transaction. Cycle 0 is the offer cycle; the model predicts, from
    // the latency rules, in which cycles each strobe must appear.
    task automatic run_txn(input string name, input logic [AW-1:0] addr, input logic ev_valid,
                           input logic [AW-1:0] ev_addr, input logic [DW-1:0] ev_data,
                           input logic v_hit, input logic [AW-1:0] v_addr, input logic [DW-1:0] v_data,
                           input int ack_dly, input logic [DW-1:0] m_data, input int flush_cyc);
        bit accepted, hit, fill, wr_exp, rv_exp, lk_prev;
        bit e_busy, e_lk, e_mreq, e_wr, e_rv;
        int last, chk_cyc, e_cyc, r_cyc, m_first, m_last, obs_mfirst;
        logic [DW-1:0] new_fill, exp_buf;

        cur_txn  = name;
        accepted = (flush_cyc != 0);
        hit      = v_hit && (v_addr == addr);
        last = 0; chk_cyc = -1; e_cyc = -1; r_cyc = -1; m_first = -1; m_last = -1; fill = 0;
        if (accepted) begin
            last = 1;
            if (flush_cyc != 1) begin
                last = 2;
                chk_cyc = 2;
                if (flush_cyc != 2) begin
                    if (hit) begin
                        e_cyc = 3;
                    end else begin
                        m_first = 3;
                        m_last  = 3 + ack_dly;
                        last    = m_last;
                        if (!(flush_cyc >= m_first && flush_cyc <= m_last)) e_cyc = m_last + 1;
                    end
                    if (e_cyc > 0) begin
                        fill = 1;
                        last = e_cyc;
                        if (flush_cyc != e_cyc) begin
                            r_cyc = e_cyc + 1;
                            last  = r_cyc;
                        end
                    end
                end
            end
        end
        new_fill = hit ? v_data : m_data;
        wr_exp   = ev_valid && (e_cyc > 0) && (flush_cyc != e_cyc);
        rv_exp   = (r_cyc > 0) && (flush_cyc != r_cyc);

        obs_mfirst = -1;
        lk_prev    = 0;
        for (int c = 0; c <= last + 2; c++) begin
            @(negedge clk);
            flush_i = (c == flush_cyc);
            if (c == 0) begin
                miss_req_i    = 1'b1;
                miss_addr_i   = addr;
                evict_valid_i = ev_valid;
                evict_addr_i  = ev_addr;
                evict_data_i  = ev_data;
            end else begin
                miss_req_i    = (c <= last) ? 1'($urandom_range(0, 1)) : 1'b0;
                miss_addr_i   = AW'($urandom);
                evict_valid_i = 1'($urandom_range(0, 1));
                evict_addr_i  = AW'($urandom);
                evict_data_i  = {$urandom(), $urandom()};
            end
            victim_hit_i  = v_hit && lk_prev;
            victim_addr_i = v_hit ? v_addr : AW'($urandom);
            victim_data_i = v_hit ? v_data : {$urandom(), $urandom()};
            mem_ack_i     = (obs_mfirst >= 0) && (c == obs_mfirst + ack_dly);
            mem_data_i    = mem_ack_i ? m_data : {$urandom(), $urandom()};
            #1;
            e_busy  = (c >= 1) && (c <= last);
            e_lk    = accepted && ((c == 1) || (c == chk_cyc));
            e_mreq  = (m_first >= 0) && (c >= m_first) && (c <= m_last);
            e_wr    = wr_exp && (c == e_cyc);
            e_rv    = rv_exp && (c == r_cyc);
            exp_buf = (fill && c >= e_cyc) ? new_fill : m_fill;
            chk("busy", busy_o, e_busy);
            chk("raddr", victim_addr_r_o, e_lk ? addr : '0);
            chk("mreq", mem_req_o, e_mreq);
            if (e_mreq) chk("maddr", mem_addr_o, addr);
            chk("wr_en", victim_wr_en_o, e_wr);
            if (e_wr) begin
                chk("waddr", victim_addr_w_o, ev_addr);
                chk("wdata", victim_data_o, ev_data);
            end
            chk("rvalid", refill_valid_o, e_rv);
            if (e_rv) chk("src", refill_from_victim_o, hit);
            chk("rdata", refill_data_o, exp_buf);
            chk("excl", ($countones({victim_wr_en_o, mem_req_o, refill_valid_o}) <= 1), 1);
            if (mem_req_o && obs_mfirst < 0) obs_mfirst = c;
            lk_prev = busy_o && (victim_addr_r_o == addr);
        end
        if (fill) m_fill = new_fill;
        if (chk_cyc > 0 && flush_cyc != 2) begin
            if (hit) m_hits++;
            else m_misses++;
        end
        flush_i = 0; miss_req_i = 0; mem_ack_i = 0; victim_hit_i = 0;
`ifdef VICTIM_SWAP_PERF_CNT_EN
        chk("hit_cnt", hit_cnt, sat(m_hits));
        chk("miss_cnt", miss_cnt, sat(m_misses));
`endif
    endtask

    // Accept a miss, then pull rst (together with flush and a new request) mid-flight.
    task automatic reset_mid(input int at, input logic v_hit);
        logic [AW-1:0] addr;
        cur_txn = "reset_mid";
        addr = AW'($urandom);
        for (int c = 0; c <= at; c++) begin
            @(negedge clk);
            miss_req_i    = (c == 0) || (c == at);
            miss_addr_i   = (c == 0) ? addr : AW'($urandom);
            evict_valid_i = 1'b1;
            evict_addr_i  = AW'($urandom);
            evict_data_i  = {$urandom(), $urandom()};
            victim_hit_i  = v_hit && (c == 2);
            victim_addr_i = addr;
            victim_data_i = {$urandom(), $urandom()};
            mem_ack_i     = 1'b0;
            flush_i       = (c == at);
            rst           = (c == at);
        end
        @(negedge clk);
        rst = 0; flush_i = 0; miss_req_i = 0; victim_hit_i = 0;
        #1;
        m_fill = '0; m_hits = 0; m_misses = 0;
        chk_idle();
        @(negedge clk);
        #1;
        chk_idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog [%s] got=timeout exp=finish", cur_txn);
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic [AW-1:0] a;
        int fl;
        repeat (3) @(negedge clk);
        #1;
        chk_idle();
        rst = 0;

        run_txn("hit_1a4",    12'h1A4, 1'b0, 12'h000, '0, 1'b1, 12'h1A4, DEAD, 3, 64'h1, -1);
        run_txn("miss_1a4",   12'h1A4, 1'b0, 12'h000, '0, 1'b0, 12'h000, '0, 3, 64'h0123_4567_89AB_CDEF, -1);
        run_txn("mismatch",   12'h1A4, 1'b0, 12'h000, '0, 1'b1, 12'h1A5, DEAD, 2, 64'h5555_AAAA_0000_FFFF, -1);
        run_txn("evict_hit",  12'h2B0, 1'b1, 12'h0C3, 64'hCAFE_F00D_1234_5678, 1'b1, 12'h2B0, DEAD, 1, '0, -1);
        run_txn("evict_miss", 12'h2B1, 1'b1, 12'h0C3, 64'h0BAD_C0DE_8765_4321, 1'b0, 12'h000, '0, 2, 64'h77, -1);
        run_txn("no_evict",   12'h2B2, 1'b0, 12'h0C3, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 12'h2B2, 64'h99, 1, '0, -1);
        run_txn("flush_chk",  12'h1A4, 1'b1, 12'h0C3, 64'h11, 1'b1, 12'h1A4, 64'h22, 1, '0, 2);
        run_txn("flush_mem",  12'h1A4, 1'b1, 12'h0C3, 64'h33, 1'b0, 12'h000, '0, 3, 64'h44, 4);
        run_txn("flush_ack",  12'h1A4, 1'b1, 12'h0C3, 64'h35, 1'b0, 12'h000, '0, 2, 64'h46, 5);
        run_txn("flush_idle", 12'h1A4, 1'b1, 12'h0C3, 64'h55, 1'b1, 12'h1A4, 64'h66, 1, '0, 0);
        run_txn("flush_lk",   12'h3C0, 1'b1, 12'h0C3, 64'h57, 1'b1, 12'h3C0, 64'h68, 1, '0, 1);
        run_txn("flush_ev",   12'h3C1, 1'b1, 12'h0C3, 64'h59, 1'b1, 12'h3C1, 64'h6A, 1, '0, 3);
        run_txn("flush_resp", 12'h3C2, 1'b1, 12'h0C3, 64'h5B, 1'b1, 12'h3C2, 64'h6C, 1, '0, 4);

        reset_mid(3, 1'b1);
        reset_mid(5, 1'b0);
        reset_mid(1, 1'b1);

        for (int i = 0; i < 17; i++) begin
            a = AW'($urandom);
            run_txn("hit17", a, 1'b0, '0, '0, 1'b1, a, {$urandom(), $urandom()}, 1, '0, -1);
        end

        for (int i = 0; i < 200; i++) begin
            a  = AW'($urandom);
            fl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 10)) : -1;
            run_txn("random", a, 1'($urandom_range(0, 1)), AW'($urandom), {$urandom(), $urandom()},
                    1'($urandom_range(0, 1)),
                    ($urandom_range(0, 2) == 0) ? (a ^ AW'(1 << $urandom_range(0, AW - 1))) : a,
                    {$urandom(), $urandom()}, int'($urandom_range(1, 6)), {$urandom(), $urandom()}, fl);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
